// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Store geometry, frame marker, loader states, opcodes.
package inst_loader_pkg;

  localparam int IW = 16;
  localparam int AW = 8;

  localparam logic [7:0]  SYNC_DEF    = 8'hA5;
  localparam logic [15:0] TIMEOUT_DEF = 16'd50000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM
  } ld_state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8
  } opcode_e;

  function automatic opcode_e op_of(
    input logic [IW-1:0] w
  );
    return opcode_e'(w[IW-1:IW-4]);
  endfunction

  function automatic logic [7:0] csum_step(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/inst_loader.sv
// Framed byte stream -> instruction RAM writer, holds CPU during load.
// Ports: clk, rst_n, in_valid/in_data/in_ready (byte stream),
//   wr_en/wr_addr/wr_data (RAM write), cpu_hold, load_done, load_err.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_DEF,
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);

  ld_state_e     state;
  logic [AW-1:0] addr;
  logic [8:0]    remaining;
  logic [7:0]    hi;
  logic [7:0]    csum;
  logic [IW-1:0] word;
  logic [15:0]   tcnt;

  logic          acc;
  logic          tmo;
  logic [8:0]    rem_dec;

  assign acc     = in_valid & in_ready;
  assign rem_dec = remaining - 9'd1;

  // Idle gap inside a frame has run its full length this cycle.
  assign tmo = (state != S_IDLE) && !acc &&
               (tcnt == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      hi        <= '0;
      csum      <= '0;
      word      <= '0;
      tcnt      <= '0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;

      if (state == S_IDLE || acc) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 16'd1;
      end

      if (tmo) begin
        // cpu_hold stays up: the store is partly written.
        load_err <= 1'b1;
        state    <= S_IDLE;
        in_ready <= 1'b1;
        tcnt     <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (acc && in_data == SYNC_BYTE) begin
              csum  <= '0;
              state <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (acc) begin
              addr     <= in_data;
              csum     <= csum_step(csum, in_data);
              cpu_hold <= 1'b1;
              state    <= S_COUNT;
            end
          end
          S_COUNT: begin
            if (acc) begin
              // A count of zero encodes a full 256-word frame.
              remaining <= (in_data == 8'd0) ?
                           9'd256 : {1'b0, in_data};
              csum      <= csum_step(csum, in_data);
              state     <= S_HI;
            end
          end
          S_HI: begin
            if (acc) begin
              hi    <= in_data;
              csum  <= csum_step(csum, in_data);
              state <= S_LO;
            end
          end
          S_LO: begin
            if (acc) begin
              word     <= {hi, in_data};
              csum     <= csum_step(csum, in_data);
              state    <= S_WRITE;
              in_ready <= 1'b0;
            end
          end
          S_WRITE: begin
            wr_en     <= 1'b1;
            wr_addr   <= addr;
            wr_data   <= word;
            addr      <= addr + 8'd1;
            remaining <= rem_dec;
            in_ready  <= 1'b1;
            state     <= (rem_dec == 9'd0) ?
                         S_CSUM : S_HI;
          end
          S_CSUM: begin
            if (acc) begin
              if (in_data == csum) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
              end else begin
                load_err  <= 1'b1;
              end
              state <= S_IDLE;
            end
          end
          default: begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader with a frame-level reference model.
// Per-cycle output compare plus literal checks on store contents.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int TO = int'(TIMEOUT_DEF);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  inst_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: frame position and pending-write flag.
  logic        m_ready, m_we, m_hold, m_done, m_err;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  bit          f_on, f_pend, f_acc, f_was_on;
  int          f_pos, f_n, f_idle;
  logic [7:0]  f_addr, f_hi, f_x;
  logic [15:0] f_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1; m_we = 0; m_hold = 0;
      m_done = 0; m_err = 0;
      m_addr = 0; m_data = 0;
      f_on = 0; f_pend = 0; f_pos = 0;
      f_n = 0; f_idle = 0; f_x = 0;
      f_addr = 0; f_hi = 0; f_word = 0;
    end else begin
      f_acc = in_valid && m_ready;
      f_was_on = f_on;
      m_we = 0; m_done = 0; m_err = 0;
      if (f_pend) begin
        m_we = 1;
        m_addr = f_addr;
        m_data = f_word;
        f_addr = f_addr + 8'd1;
        f_pend = 0;
      end else if (!f_on) begin
        if (f_acc && in_data == SYNC_DEF) begin
          f_on = 1; f_pos = 0; f_x = 0;
        end
      end else if (f_acc) begin
        if (f_pos == 0) begin
          f_addr = in_data;
          f_x = f_x ^ in_data;
          m_hold = 1;
        end else if (f_pos == 1) begin
          f_n = (in_data == 0) ? 256 : int'(in_data);
          f_x = f_x ^ in_data;
        end else if (f_pos < 2 + 2 * f_n) begin
          f_x = f_x ^ in_data;
          if ((f_pos % 2) == 0) begin
            f_hi = in_data;
          end else begin
            f_word = {f_hi, in_data};
            f_pend = 1;
          end
        end else begin
          if (in_data == f_x) begin
            m_done = 1; m_hold = 0;
          end else begin
            m_err = 1;
          end
          f_on = 0;
        end
        f_pos++;
      end
      if (f_was_on) begin
        if (f_acc) begin
          f_idle = 0;
        end else begin
          f_idle++;
          if (f_idle == TO) begin
            m_err = 1; f_on = 0; f_idle = 0;
          end
        end
      end else begin
        f_idle = 0;
      end
      m_ready = !f_pend;
    end
  end

  // DUT-side RAM image and pulse tallies.
  logic [15:0] ram [256];
  int n_done = 0;
  int n_err = 0;
  int n_wr = 0;

  always @(negedge clk) begin
    compared++;
    if ({in_ready, wr_en, wr_addr, wr_data,
         cpu_hold, load_done, load_err} !==
        {m_ready, m_we, m_addr, m_data,
         m_hold, m_done, m_err}) begin
      mismatched++;
      $display("FAIL cycle t=%0t got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b want rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b",
        $time, in_ready, wr_en, wr_addr, wr_data,
        cpu_hold, load_done, load_err,
        m_ready, m_we, m_addr, m_data,
        m_hold, m_done, m_err);
    end
    if (wr_en) begin
      ram[wr_addr] = wr_data;
      n_wr++;
    end
    if (load_done) n_done++;
    if (load_err) n_err++;
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  int gapmax = 2;
  logic [15:0] fw [256];

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n;
    int g;
    in_valid = 1'b1;
    in_data = b;
    ok = 0;
    n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL handshake byte %h in_ready 0 want 1", b);
    end
    #1;
    in_valid = 1'b0;
    g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] a,
                            input logic [7:0] c,
                            input bit bad);
    int n;
    logic [7:0] x;
    n = (c == 0) ? 256 : int'(c);
    x = a ^ c;
    send_byte(SYNC_DEF);
    send_byte(a);
    send_byte(c);
    for (int i = 0; i < n; i++) begin
      x = x ^ fw[i][15:8] ^ fw[i][7:0];
      send_byte(fw[i][15:8]);
      send_byte(fw[i][7:0]);
    end
    send_byte(bad ? (x ^ 8'hFF) : x);
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int d0, e0, w0;
  int exp_done, exp_err;
  logic [7:0] ra, rc, gb;
  bit rbad;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1 by hand: csum = 10^02^31^05^82^21 = 85.
    gapmax = 1;
    send_byte(8'hA5);
    send_byte(8'h10);
    chk("t1_hold_after_addr", 32'(cpu_hold), 32'd1);
    send_byte(8'h02);
    send_byte(8'h31);
    send_byte(8'h05);
    send_byte(8'h82);
    send_byte(8'h21);
    send_byte(8'h85);
    settle();
    chk("t1_ram10", 32'(ram[8'h10]), 32'h3105);
    chk("t1_ram11", 32'(ram[8'h11]), 32'h8221);
    chk("t1_done", 32'(n_done), 32'd1);
    chk("t1_err", 32'(n_err), 32'd0);
    chk("t1_hold", 32'(cpu_hold), 32'd0);

    // Bad checksum: words stay written, hold sticks.
    ram[8'h10] = 16'h0;
    ram[8'h11] = 16'h0;
    fw[0] = 16'h3105;
    fw[1] = 16'h8221;
    send_frame(8'h10, 8'h02, 1'b1);
    settle();
    chk("t2_ram10", 32'(ram[8'h10]), 32'h3105);
    chk("t2_ram11", 32'(ram[8'h11]), 32'h8221);
    chk("t2_err", 32'(n_err), 32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd1);
    fw[0] = 16'h1A2B;
    send_frame(8'h40, 8'h01, 1'b0);
    settle();
    chk("t2_done", 32'(n_done), 32'd2);
    chk("t2_hold_clear", 32'(cpu_hold), 32'd0);

    // Address wrap FF -> 00.
    fw[0] = 16'h1234;
    fw[1] = 16'h5678;
    send_frame(8'hFF, 8'h02, 1'b0);
    settle();
    chk("t3_ramFF", 32'(ram[8'hFF]), 32'h1234);
    chk("t3_ram00", 32'(ram[8'h00]), 32'h5678);

    // COUNT=0 means 256 words, back-to-back.
    gapmax = 0;
    for (int i = 0; i < 256; i++) fw[i] = 16'($urandom);
    w0 = n_wr;
    d0 = n_done;
    send_frame(8'h00, 8'h00, 1'b0);
    settle();
    chk("t4_writes", 32'(n_wr - w0), 32'd256);
    chk("t4_done", 32'(n_done - d0), 32'd1);
    chk("t4_ram00", 32'(ram[8'h00]), 32'(fw[0]));
    chk("t4_ramFF", 32'(ram[8'hFF]), 32'(fw[255]));

    // Stall after a HI byte until the timeout fires.
    e0 = n_err;
    d0 = n_done;
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'hAB);
    in_valid = 1'b0;
    repeat (TO + 3) @(posedge clk);
    #1;
    chk("t5_err", 32'(n_err - e0), 32'd1);
    chk("t5_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00);
    send_byte(8'hFF);
    settle();
    chk("t5_garbage_err", 32'(n_err - e0), 32'd1);
    chk("t5_garbage_done", 32'(n_done - d0), 32'd0);
    fw[0] = 16'hC0DE;
    send_frame(8'h21, 8'h01, 1'b0);
    settle();
    chk("t5_recover_done", 32'(n_done - d0), 32'd1);
    chk("t5_ram21", 32'(ram[8'h21]), 32'hC0DE);

    // Reset in the middle of a frame, during the write cycle.
    e0 = n_err;
    d0 = n_done;
    send_byte(8'hA5);
    send_byte(8'h30);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    in_valid = 1'b1;
    in_data = 8'h33;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t6_rst_hold", 32'(cpu_hold), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_wr_data", 32'(wr_data), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    chk("t6_no_done", 32'(n_done - d0), 32'd0);
    chk("t6_no_err", 32'(n_err - e0), 32'd0);

    // Random frames with idle garbage and in-band A5 bytes.
    gapmax = 3;
    exp_done = n_done;
    exp_err = n_err;
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        gb = 8'($urandom);
        if (gb == SYNC_DEF) gb = 8'h5A;
        send_byte(gb);
      end
      ra = 8'($urandom);
      rc = 8'($urandom_range(1, 6));
      rbad = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < int'(rc); i++) begin
        fw[i] = 16'($urandom);
        if ($urandom_range(0, 7) == 0) fw[i][15:8] = SYNC_DEF;
      end
      send_frame(ra, rc, rbad);
      if (rbad) exp_err++;
      else exp_done++;
    end
    settle();
    chk("rand_done", 32'(n_done), 32'(exp_done));
    chk("rand_err", 32'(n_err), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
